alu_cmd_issuer: RTL and testbench

- Sequential initiator that drives the combinational alu_simple datapath.
- Accepts one ALU command through a valid/ready handshake and holds operands and controls stable on the ALU inputs for a programmable settle time.
- Captures Out/Flags, then presents the result through a second valid/ready handshake.
- Maintains a status-flag register that updates only on S=1 commands; sits between the decode stage and writeback.

---
 rtl/alu_cmd_issuer.sv | 143 ++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// Command issuer for the alu_simple datapath: latches a command, lets the ALU settle, then captures and presents the result.
// Optional performance counters (op_count, abort_count) are enabled with `define ALU_CMD_ISSUER_PERFCNT_EN.
module alu_cmd_issuer #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_in1,
    input  logic [WIDTH-1:0] cmd_in2,
    input  logic [3:0]       cmd_opcode,
    input  logic [4:0]       cmd_sr_bit,
    input  logic [2:0]       cmd_sr_cont,
    input  logic             cmd_s,
    input  logic             abort,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [3:0]       alu_opcode,
    output logic [4:0]       alu_sr_bit,
    output logic [2:0]       alu_sr_cont,
    output logic             alu_s,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [3:0]       alu_flags,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [3:0]       res_flags,
    output logic [3:0]       status_flags,
`ifdef ALU_CMD_ISSUER_PERFCNT_EN
    output logic [15:0]      op_count,
    output logic [7:0]       abort_count,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] in1_q;
    logic [WIDTH-1:0] in2_q;
    logic [3:0]       opcode_q;
    logic [4:0]       sr_bit_q;
    logic [2:0]       sr_cont_q;
    logic             s_q;
    logic [WIDTH-1:0] res_data_q;
    logic [3:0]       res_flags_q;
    logic [3:0]       status_q;
`ifdef ALU_CMD_ISSUER_PERFCNT_EN
    logic [15:0]      op_cnt_q;
    logic [7:0]       abort_cnt_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            opcode_q    <= '0;
            sr_bit_q    <= '0;
            sr_cont_q   <= '0;
            s_q         <= 1'b0;
            res_data_q  <= '0;
            res_flags_q <= '0;
            status_q    <= '0;
`ifdef ALU_CMD_ISSUER_PERFCNT_EN
            op_cnt_q    <= '0;
            abort_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        in1_q     <= cmd_in1;
                        in2_q     <= cmd_in2;
                        opcode_q  <= cmd_opcode;
                        sr_bit_q  <= cmd_sr_bit;
                        sr_cont_q <= cmd_sr_cont;
                        s_q       <= cmd_s;
                        cnt_q     <= CNT_INIT;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // abort wins over a capture due on the same edge
                    if (abort) begin
                        state_q <= S_IDLE;
`ifdef ALU_CMD_ISSUER_PERFCNT_EN
                        if (abort_cnt_q != '1) begin
                            abort_cnt_q <= abort_cnt_q + 8'd1;
                        end
`endif
                    end else if (cnt_q == '0) begin
                        res_data_q  <= alu_out;
                        res_flags_q <= alu_flags;
                        if (s_q) begin
                            status_q <= alu_flags;
                        end
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        state_q <= S_IDLE;
`ifdef ALU_CMD_ISSUER_PERFCNT_EN
                        op_cnt_q <= op_cnt_q + 16'd1;
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready    = (state_q == S_IDLE) && !rst;
    assign res_valid    = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE);
    assign alu_in1      = in1_q;
    assign alu_in2      = in2_q;
    assign alu_opcode   = opcode_q;
    assign alu_sr_bit   = sr_bit_q;
    assign alu_sr_cont  = sr_cont_q;
    assign alu_s        = s_q;
    assign res_data     = res_data_q;
    assign res_flags    = res_flags_q;
    assign status_flags = status_q;
`ifdef ALU_CMD_ISSUER_PERFCNT_EN
    assign op_count     = op_cnt_q;
    assign abort_count  = abort_cnt_q;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural alu_simple model closing the loop.
// Flags model: {N, Z, C, V}; C is carry-out for add, not-borrow for sub.
module tb_alu_cmd_issuer;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_in1;
    logic [W-1:0]  cmd_in2;
    logic [3:0]    cmd_opcode;
    logic [4:0]    cmd_sr_bit;
    logic [2:0]    cmd_sr_cont;
    logic          cmd_s;
    logic          abort;
    logic [W-1:0]  alu_in1;
    logic [W-1:0]  alu_in2;
    logic [3:0]    alu_opcode;
    logic [4:0]    alu_sr_bit;
    logic [2:0]    alu_sr_cont;
    logic          alu_s;
    logic [W-1:0]  alu_out;
    logic [3:0]    alu_flags;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_data;
    logic [3:0]    res_flags;
    logic [3:0]    status_flags;
    logic          busy;
`ifdef ALU_CMD_ISSUER_PERFCNT_EN
    logic [15:0]   op_count;
    logic [7:0]    abort_count;
`endif

    always #5 clk = ~clk;

    alu_cmd_issuer #(.WIDTH(W), .SETTLE_CYCLES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_in1      (cmd_in1),
        .cmd_in2      (cmd_in2),
        .cmd_opcode   (cmd_opcode),
        .cmd_sr_bit   (cmd_sr_bit),
        .cmd_sr_cont  (cmd_sr_cont),
        .cmd_s        (cmd_s),
        .abort        (abort),
        .alu_in1      (alu_in1),
        .alu_in2      (alu_in2),
        .alu_opcode   (alu_opcode),
        .alu_sr_bit   (alu_sr_bit),
        .alu_sr_cont  (alu_sr_cont),
        .alu_s        (alu_s),
        .alu_out      (alu_out),
        .alu_flags    (alu_flags),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_flags    (res_flags),
        .status_flags (status_flags),
`ifdef ALU_CMD_ISSUER_PERFCNT_EN
        .op_count     (op_count),
        .abort_count  (abort_count),
`endif
        .busy         (busy)
    );

    // Behavioural alu_simple: shift/rotate applies to In2 before the operation.
    logic [W-1:0]   sh;
    logic [2*W-1:0] rot;
    logic [W:0]     sum;
    logic [W-1:0]   r;
    logic           c;
    logic           v;
    always_comb begin
        rot = {alu_in2, alu_in2} >> alu_sr_bit;
        sh  = alu_in2;
        sum = '0;
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (alu_sr_cont)
            3'd1:    sh = alu_in2 >> alu_sr_bit;
            3'd2:    sh = alu_in2 << alu_sr_bit;
            3'd3:    sh = rot[W-1:0];
            default: sh = alu_in2;
        endcase
        case (alu_opcode)
            4'd0: begin
                sum = {1'b0, alu_in1} + {1'b0, sh};
                r   = sum[W-1:0];
                c   = sum[W];
                v   = (alu_in1[W-1] == sh[W-1]) && (r[W-1] != alu_in1[W-1]);
            end
            4'd1: begin
                sum = {1'b0, alu_in1} + {1'b0, ~sh} + {{W{1'b0}}, 1'b1};
                r   = sum[W-1:0];
                c   = sum[W];
                v   = (alu_in1[W-1] != sh[W-1]) && (r[W-1] != alu_in1[W-1]);
            end
            4'd2:    r = alu_in1 * sh;
            4'd3:    r = alu_in1 | sh;
            4'd4:    r = alu_in1 & sh;
            4'd5:    r = alu_in1 ^ sh;
            default: r = '0;
        endcase
        alu_out   = r;
        alu_flags = {r[W-1], (r == '0), c, v};
    end

    int checks   = 0;
    int failures = 0;
    int exp_ops    = 0;
    int exp_aborts = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  op;
        logic [4:0]  sb;
        logic [2:0]  sc;
        logic        s;
        logic [31:0] data;
        logic [3:0]  flags;
        logic [3:0]  status;
    } vec_t;

    vec_t vecs[10];

    // Called at a negedge; returns 1 ns after the accepting edge.
    task automatic send(input vec_t v);
        cmd_in1     = v.in1;
        cmd_in2     = v.in2;
        cmd_opcode  = v.op;
        cmd_sr_bit  = v.sb;
        cmd_sr_cont = v.sc;
        cmd_s       = v.s;
        cmd_valid   = 1'b1;
        #1;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("alu_in2_latched", alu_in2, v.in2);
    endtask

    task automatic wait_result(output int n);
        n = 0;
        while (!res_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        send(v);
        wait_result(n);
        chk("latency", 32'(n), 32'd2);
        chk("res_data", res_data, v.data);
        chk("res_flags", 32'(res_flags), 32'(v.flags));
        chk("status_flags", 32'(status_flags), 32'(v.status));
        chk("cmd_ready_done", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        exp_ops++;
        chk("res_valid_drop", 32'(res_valid), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    vec_t vm;
    int   nlat;

    initial begin
        //          in1           in2           op    sb    sc    s     data          flags    status
        vecs[0] = '{32'd15,       32'd20,       4'd0, 5'd0, 3'd0, 1'b1, 32'd35,       4'b0000, 4'b0000};
        vecs[1] = '{32'd30,       32'd10,       4'd1, 5'd0, 3'd0, 1'b1, 32'd20,       4'b0010, 4'b0010};
        vecs[2] = '{32'h0FF,      32'h0F0,      4'd5, 5'd0, 3'd0, 1'b0, 32'h00F,      4'b0000, 4'b0010};
        vecs[3] = '{32'd30,       32'd10,       4'd0, 5'd4, 3'd3, 1'b1, 32'hA000001E, 4'b1000, 4'b1000};
        vecs[4] = '{32'd30,       32'd10,       4'd0, 5'd4, 3'd2, 1'b0, 32'd190,      4'b0000, 4'b1000};
        vecs[5] = '{32'd7,        32'd7,        4'd1, 5'd0, 3'd0, 1'b1, 32'd0,        4'b0110, 4'b0110};
        vecs[6] = '{32'hFFFFFFFF, 32'd1,        4'd0, 5'd0, 3'd0, 1'b0, 32'd0,        4'b0110, 4'b0110};
        vecs[7] = '{32'hF0,       32'h0F,       4'd3, 5'd0, 3'd0, 1'b0, 32'hFF,       4'b0000, 4'b0110};
        vecs[8] = '{32'd0,        32'h80,       4'd0, 5'd4, 3'd1, 1'b0, 32'd8,        4'b0000, 4'b0110};
        vecs[9] = '{32'hF0F0,     32'hFF00,     4'd4, 5'd0, 3'd0, 1'b1, 32'hF000,     4'b0000, 4'b0000};

        rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0; res_ready = 1'b1;
        cmd_in1 = '0; cmd_in2 = '0; cmd_opcode = '0; cmd_sr_bit = '0; cmd_sr_cont = '0; cmd_s = 1'b0;
        repeat (2) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_in1   = 32'h55;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_alu_in1", alu_in1, 32'd0);
        chk("rst_status", 32'(status_flags), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        cmd_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        // alu_* are registered and hold the last command in IDLE
        cmd_in1    = 32'h1234;
        cmd_opcode = 4'd2;
        #1;
        chk("alu_in1_hold", alu_in1, 32'hF0F0);
        chk("alu_opcode_hold", 32'(alu_opcode), 32'd4);
        @(negedge clk);

        // Backpressure: result held while res_ready=0, new command not taken
        res_ready = 1'b0;
        vm = '{32'd5, 32'd5, 4'd2, 5'd0, 3'd0, 1'b0, 32'd25, 4'b0000, 4'b0000};
        send(vm);
        wait_result(nlat);
        chk("bp_latency", 32'(nlat), 32'd2);
        cmd_in1   = 32'd99;
        cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_res_valid", 32'(res_valid), 32'd1);
            chk("bp_res_data", res_data, 32'd25);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        exp_ops++;
        chk("bp_idle", 32'(busy), 32'd0);
        chk("bp_res_valid_drop", 32'(res_valid), 32'd0);
        chk("bp_not_accepted", alu_in1, 32'd5);
        @(negedge clk);

        // Abort in first WAIT cycle: no capture, no status update
        send(vecs[5]);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        exp_aborts++;
        chk("abort_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(res_valid), 32'd0);
        end
        chk("abort_status", 32'(status_flags), 32'd0);

`ifdef ALU_CMD_ISSUER_PERFCNT_EN
        chk("op_count", 32'(op_count), 32'(exp_ops));
        chk("abort_count", 32'(abort_count), 32'(exp_aborts));
`endif

        // Reset mid-WAIT clears everything immediately; next command is normal
        run_vec(vecs[5]);
        send(vecs[0]);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_alu_in1", alu_in1, 32'd0);
        chk("midrst_res_data", res_data, 32'd0);
        chk("midrst_res_flags", 32'(res_flags), 32'd0);
        chk("midrst_status", 32'(status_flags), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_ops = 0;
        exp_aborts = 0;
        @(negedge clk);
        run_vec(vecs[1]);

`ifdef ALU_CMD_ISSUER_PERFCNT_EN
        chk("op_count_after_rst", 32'(op_count), 32'(exp_ops));
        chk("abort_count_after_rst", 32'(abort_count), 32'(exp_aborts));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
